// File: rtl/alu_bus_sequencer.sv
// alu_bus_sequencer: sequences one ALU operation from start to write-back.
// It pulses the ALU start and waits the execution latency. It then strobes the
// result latch, and moves the result over the shared 8-bit bus one byte per
// granted cycle: low byte always, high byte as well for multiply.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous active-low reset
//   start      - request a new operation (sampled in IDLE only)
//   is_mul     - operation returns 16 bits; sampled with start
//   abort      - synchronous cancel; forces strobes low in the same cycle
//   bus_gnt    - data bus granted for the current cycle
//   busy       - high in every state except IDLE
//   alu_start  - one-cycle pulse to the ALU
//   grab       - one-cycle capture strobe to the ALU result latch
//   bus_req    - data bus request
//   store_low  - latch low byte onto bus (follows bus_gnt in BUS_LO)
//   store_high - latch high byte onto bus (follows bus_gnt in BUS_HI)
//   wr_low     - destination low-byte register write strobe
//   wr_high    - destination high-byte register write strobe
//   done       - one-cycle completion pulse
//
// Outputs are decoded from the state register plus the same-cycle abort and
// bus_gnt inputs. Because state resets asynchronously, every output drops as
// soon as reset asserts, which releases the bus without waiting for an edge.
module alu_bus_sequencer #(
  parameter int unsigned ALU_LATENCY = 1,
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic is_mul,
  input  logic abort,
  input  logic bus_gnt,
  output logic busy,
  output logic alu_start,
  output logic grab,
  output logic bus_req,
  output logic store_low,
  output logic store_high,
  output logic wr_low,
  output logic wr_high,
  output logic done
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_GRAB,
    S_BUS_LO,
    S_BUS_HI,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mul_q, mul_d;
  logic               first_q, first_d;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mul_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_q   <= mul_d;
      first_q <= first_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mul_d      = mul_q;
    first_d    = 1'b0;
    busy       = (state_q != S_IDLE);
    alu_start  = 1'b0;
    grab       = 1'b0;
    bus_req    = 1'b0;
    store_low  = 1'b0;
    store_high = 1'b0;
    wr_low     = 1'b0;
    wr_high    = 1'b0;
    done       = 1'b0;

    if (abort) begin
      // Cancel wins over start and grant; all strobes stay low this cycle.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_EXEC;
            mul_d   = is_mul;
            cnt_d   = is_mul ? CNT_W'(MUL_LATENCY - 1) : CNT_W'(ALU_LATENCY - 1);
            first_d = 1'b1;
          end
        end
        S_EXEC: begin
          // first_q marks the first EXEC cycle so latency 1 still pulses.
          alu_start = first_q;
          if (cnt_q == '0) begin
            state_d = S_GRAB;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_GRAB: begin
          grab    = 1'b1;
          state_d = S_BUS_LO;
        end
        S_BUS_LO: begin
          bus_req   = 1'b1;
          store_low = bus_gnt;
          wr_low    = bus_gnt;
          if (bus_gnt) begin
            state_d = mul_q ? S_BUS_HI : S_DONE;
          end
        end
        S_BUS_HI: begin
          bus_req    = 1'b1;
          store_high = bus_gnt;
          wr_high    = bus_gnt;
          if (bus_gnt) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// Testbench for alu_bus_sequencer: directed per-cycle vector tables, hand-written
// reset and throughput sequences, then randomized traffic against a
// transaction-level reference model.
module tb_alu_bus_sequencer;

  localparam int unsigned ALU_LAT = 1;
  localparam int unsigned MUL_LAT = 4;

  // Output vector order: {busy, alu_start, grab, bus_req, store_low,
  //                       store_high, wr_low, wr_high, done}
  localparam logic [8:0] O_IDLE  = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] O_EXEC1 = 9'b1_1_0_0_0_0_0_0_0;
  localparam logic [8:0] O_BUSY  = 9'b1_0_0_0_0_0_0_0_0;
  localparam logic [8:0] O_GRAB  = 9'b1_0_1_0_0_0_0_0_0;
  localparam logic [8:0] O_WAIT  = 9'b1_0_0_1_0_0_0_0_0;
  localparam logic [8:0] O_LO    = 9'b1_0_0_1_1_0_1_0_0;
  localparam logic [8:0] O_HI    = 9'b1_0_0_1_0_1_0_1_0;
  localparam logic [8:0] O_DONE  = 9'b1_0_0_0_0_0_0_0_1;

  logic clock;
  logic reset;
  logic start, is_mul, abort, bus_gnt;
  logic busy, alu_start, grab, bus_req, store_low, store_high, wr_low, wr_high, done;
  logic [8:0] outs;

  int checks = 0;
  int errors = 0;

  alu_bus_sequencer #(
    .ALU_LATENCY(ALU_LAT),
    .MUL_LATENCY(MUL_LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .is_mul(is_mul),
    .abort(abort),
    .bus_gnt(bus_gnt),
    .busy(busy),
    .alu_start(alu_start),
    .grab(grab),
    .bus_req(bus_req),
    .store_low(store_low),
    .store_high(store_high),
    .wr_low(wr_low),
    .wr_high(wr_high),
    .done(done)
  );

  assign outs = {busy, alu_start, grab, bus_req, store_low, store_high, wr_low, wr_high, done};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_outs(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (busy,alu_start,grab,bus_req,st_lo,st_hi,wr_lo,wr_hi,done)",
               name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Directed vectors: inputs for one cycle plus the outputs expected in it.
  typedef struct {
    logic       start;
    logic       is_mul;
    logic       abort;
    logic       gnt;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic m, input logic a, input logic g,
                              input logic [8:0] e);
    vec_t v;
    v.start = s; v.is_mul = m; v.abort = a; v.gnt = g; v.exp = e;
    return v;
  endfunction

  // Reference model: an operation is an elapsed-cycle count plus bytes moved.
  bit m_active;
  bit m_mul;
  int m_t;
  int m_sent;

  function automatic logic [8:0] model_out(input logic a, input logic g);
    int lat;
    int nbytes;
    logic [8:0] o;
    o = O_IDLE;
    if (!m_active) return o;
    o[8] = 1'b1;
    if (a) return o;
    lat    = m_mul ? int'(MUL_LAT) : int'(ALU_LAT);
    nbytes = m_mul ? 2 : 1;
    if (m_t <= lat) begin
      o[7] = (m_t == 1);
    end else if (m_t == lat + 1) begin
      o[6] = 1'b1;
    end else if (m_sent < nbytes) begin
      o[5] = 1'b1;
      if (g) begin
        if (m_sent == 0) begin o[4] = 1'b1; o[2] = 1'b1; end
        else             begin o[3] = 1'b1; o[1] = 1'b1; end
      end
    end else begin
      o[0] = 1'b1;
    end
    return o;
  endfunction

  task automatic model_step(input logic s, input logic m, input logic a, input logic g);
    int lat;
    int nbytes;
    lat    = m_mul ? int'(MUL_LAT) : int'(ALU_LAT);
    nbytes = m_mul ? 2 : 1;
    if (!m_active) begin
      if (s && !a) begin
        m_active = 1'b1; m_mul = m; m_t = 1; m_sent = 0;
      end
    end else if (a) begin
      m_active = 1'b0;
    end else if (m_t <= lat + 1) begin
      m_t++;
    end else if (m_sent < nbytes) begin
      if (g) m_sent++;
    end else begin
      m_active = 1'b0;
    end
  endtask

  task automatic drive(input logic s, input logic m, input logic a, input logic g);
    start = s; is_mul = m; abort = a; bus_gnt = g;
  endtask

  initial begin
    int last_done;
    int n_done;
    logic [8:0] exp;
    logic s, m, a, g;

    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check_outs("reset_state", outs, O_IDLE);
    @(negedge clock);
    reset = 1'b1;

    // Non-multiply, grant tied high; start during DONE must be ignored.
    vecs.push_back(mk(1, 0, 0, 1, O_IDLE));
    vecs.push_back(mk(0, 0, 0, 1, O_EXEC1));
    vecs.push_back(mk(0, 0, 0, 1, O_GRAB));
    vecs.push_back(mk(0, 0, 0, 1, O_LO));
    vecs.push_back(mk(1, 0, 0, 1, O_DONE));
    vecs.push_back(mk(0, 0, 0, 1, O_IDLE));
    vecs.push_back(mk(0, 0, 0, 1, O_IDLE));
    // Multiply with grant waits in both byte phases.
    vecs.push_back(mk(1, 1, 0, 0, O_IDLE));
    vecs.push_back(mk(0, 0, 0, 0, O_EXEC1));
    vecs.push_back(mk(0, 0, 0, 0, O_BUSY));
    vecs.push_back(mk(0, 0, 0, 0, O_BUSY));
    vecs.push_back(mk(0, 0, 0, 0, O_BUSY));
    vecs.push_back(mk(0, 0, 0, 0, O_GRAB));
    vecs.push_back(mk(0, 0, 0, 0, O_WAIT));
    vecs.push_back(mk(0, 0, 0, 0, O_WAIT));
    vecs.push_back(mk(0, 0, 0, 0, O_WAIT));
    vecs.push_back(mk(0, 0, 0, 1, O_LO));
    vecs.push_back(mk(0, 0, 0, 0, O_WAIT));
    vecs.push_back(mk(0, 0, 0, 0, O_WAIT));
    vecs.push_back(mk(0, 0, 0, 1, O_HI));
    vecs.push_back(mk(0, 0, 0, 0, O_DONE));
    vecs.push_back(mk(0, 0, 0, 0, O_IDLE));
    // Multiply aborted in BUS_HI with grant high, then abort beats start in IDLE.
    vecs.push_back(mk(1, 1, 0, 1, O_IDLE));
    vecs.push_back(mk(0, 0, 0, 1, O_EXEC1));
    vecs.push_back(mk(0, 0, 0, 1, O_BUSY));
    vecs.push_back(mk(0, 0, 0, 1, O_BUSY));
    vecs.push_back(mk(0, 0, 0, 1, O_BUSY));
    vecs.push_back(mk(0, 0, 0, 1, O_GRAB));
    vecs.push_back(mk(0, 0, 0, 1, O_LO));
    vecs.push_back(mk(0, 0, 1, 1, O_BUSY));
    vecs.push_back(mk(1, 0, 1, 1, O_IDLE));
    vecs.push_back(mk(0, 0, 0, 1, O_IDLE));

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].start, vecs[i].is_mul, vecs[i].abort, vecs[i].gnt);
      #1;
      check_outs($sformatf("vec%0d", i), outs, vecs[i].exp);
    end

    // Async reset mid-EXEC drops outputs without a clock edge.
    @(negedge clock); drive(1, 1, 0, 1);
    @(negedge clock); drive(0, 0, 0, 1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check_outs("async_rst_exec", outs, O_IDLE);
    @(negedge clock); reset = 1'b1; drive(1, 0, 0, 1);
    @(negedge clock); drive(0, 0, 0, 1);
    #1 check_outs("restart_exec", outs, O_EXEC1);
    @(negedge clock); #1 check_outs("restart_grab", outs, O_GRAB);
    // Async reset while the low byte is on the bus releases it immediately.
    @(negedge clock); #1 check_outs("restart_lo", outs, O_LO);
    #1 reset = 1'b0;
    #1 check_outs("async_rst_bus", outs, O_IDLE);
    @(negedge clock); reset = 1'b1;

    // Back-to-back throughput with start held high.
    @(negedge clock); drive(1, 0, 0, 1);
    last_done = -1;
    n_done = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      if (done) begin
        check_int($sformatf("done_cycle%0d", n_done), cyc, (last_done < 0) ? 4 : last_done + 5);
        last_done = cyc;
        n_done++;
      end
      @(negedge clock);
    end
    check_int("done_count", n_done, 6);
    drive(0, 0, 0, 1);
    for (int k = 0; k < 8; k++) @(negedge clock);
    #1 check_outs("idle_after_tput", outs, O_IDLE);

    // Randomized traffic against the reference model.
    m_active = 1'b0; m_mul = 1'b0; m_t = 0; m_sent = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      s = 1'($urandom_range(1, 0));
      m = 1'($urandom_range(1, 0));
      a = ($urandom_range(31, 0) == 0);
      g = ($urandom_range(3, 0) != 0);
      drive(s, m, a, g);
      #1;
      exp = model_out(a, g);
      check_outs($sformatf("rand%0d", k), outs, exp);
      model_step(s, m, a, g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
